// File: rtl/rev_gate_inverter.sv
// Sequential reversible-gate executor: runs a stored NOT/CNOT/Toffoli program on {A,B,C},
// forward or inverse. Optional illegal-gate trapping is enabled by defining GATE_CHECK_EN.
module rev_gate_inverter #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          dir,
    input  logic          A,
    input  logic          B,
    input  logic          C,
    output logic [2:0]    Out,
    output logic          busy,
    output logic          done,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t        state, state_n;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] pc;
    logic [AW:0]   cnt;
    logic [AW:0]   len_c;
    logic          dir_r;
    logic [2:0]    out_r;

    logic [7:0]    entry;
    logic [1:0]    op, tgt, c1, c2;
    logic          illegal;
    logic [3:0]    sx;
    logic [3:0]    onehot;
    logic          flip;
    logic [2:0]    out_n;

    assign len_c = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;

    assign entry = mem[pc];
    assign op    = entry[7:6];
    assign tgt   = entry[5:4];
    assign c1    = entry[3:2];
    assign c2    = entry[1:0];

    // Controls are only "used" by the ops that read them; NOP uses nothing.
    always_comb begin
        illegal = 1'b0;
        if (op != 2'b00 && tgt == 2'd3)
            illegal = 1'b1;
        if (op[1] && (c1 == 2'd3 || c1 == tgt))
            illegal = 1'b1;
        if (op == 2'b11 && (c2 == 2'd3 || c2 == tgt))
            illegal = 1'b1;
    end

    // Padding index 3 to zero keeps every select in range; illegal gates flip nothing.
    assign sx     = {1'b0, out_r};
    assign onehot = 4'b0001 << tgt;
    always_comb begin
        flip = 1'b0;
        case (op)
            2'b01:   flip = 1'b1;
            2'b10:   flip = sx[c1];
            2'b11:   flip = sx[c1] & sx[c2];
            default: flip = 1'b0;
        endcase
    end
    assign out_n = (illegal || !flip) ? out_r : (out_r ^ onehot[2:0]);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start) state_n = (len_c == '0) ? DONE : RUN;
            RUN: begin
`ifdef GATE_CHECK_EN
                if (illegal) state_n = DONE;
                else
`endif
                if (cnt == (AW+1)'(1)) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
            out_r <= 3'b000;
            pc    <= '0;
            cnt   <= '0;
            dir_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (prog_we) mem[prog_addr] <= prog_data;
                    if (start) begin
                        out_r <= {A, B, C};
                        pc    <= dir ? AW'(len_c - (AW+1)'(1)) : '0;
                        cnt   <= len_c;
                        dir_r <= dir;
                    end
                end
                RUN: begin
                    out_r <= out_n;
                    pc    <= dir_r ? pc - AW'(1) : pc + AW'(1);
                    cnt   <= cnt - (AW+1)'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef GATE_CHECK_EN
    logic err_r;
    always_ff @(posedge clk) begin
        if (rst)
            err_r <= 1'b0;
        else if (state == IDLE && start)
            err_r <= 1'b0;
        else if (state == RUN && illegal)
            err_r <= 1'b1;
    end
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign Out  = out_r;
    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_rev_gate_inverter.sv
// Directed self-checking bench for rev_gate_inverter with hand-computed expectations.
module tb_rev_gate_inverter;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [7:0]    prog_data;
    logic [AW:0]   prog_len;
    logic          start, dir, A, B, C;
    logic [2:0]    Out;
    logic          busy, done, err;

    int checks   = 0;
    int failures = 0;

    rev_gate_inverter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start), .dir(dir),
        .A(A), .B(B), .C(C), .Out(Out), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic prog_write(input logic [AW-1:0] addr, input logic [7:0] data);
        @(posedge clk); #1;
        prog_we = 1'b1; prog_addr = addr; prog_data = data;
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    // Launches one execution and measures it; lat counts cycles from start to done.
    task automatic run(input logic [AW:0] len, input logic d, input logic [2:0] abc,
                       input bit we0, input logic [7:0] wdata, input bit disturb,
                       output logic [2:0] res, output int lat, output int bcnt,
                       output logic dafter, output logic eres);
        @(posedge clk); #1;
        start = 1'b1; prog_len = len; dir = d; {A, B, C} = abc;
        if (we0) begin prog_we = 1'b1; prog_addr = '0; prog_data = wdata; end
        @(posedge clk); #1;
        start = 1'b0; prog_we = 1'b0; {A, B, C} = ~abc;
        lat = 1; bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            if (disturb && lat == 1) begin
                start = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_data = 8'h40;
                {A, B, C} = 3'b000;
            end else begin
                start = 1'b0; prog_we = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0; prog_we = 1'b0;
        res = Out; eres = err;
        @(posedge clk); #1;
        dafter = done;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        checks++; if (Out !== 3'b000) begin failures++; $display("FAIL reset_out got=%b exp=000", Out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    endtask

    task automatic test_toffoli;
        logic [2:0] r; int lat, bc; logic da, e;
        prog_write(3'd0, 8'hC9);
        run(4'd1, 1'b0, 3'b110, 1'b0, 8'h00, 1'b0, r, lat, bc, da, e);
        checks++; if (r !== 3'b111) begin failures++; $display("FAIL toffoli_out got=%b exp=111", r); end
        checks++; if (lat != 2) begin failures++; $display("FAIL toffoli_latency got=%0d exp=2", lat); end
        checks++; if (bc != 1) begin failures++; $display("FAIL toffoli_busy got=%0d exp=1", bc); end
        checks++; if (da !== 1'b0) begin failures++; $display("FAIL toffoli_done_pulse got=%b exp=0", da); end
    endtask

    task automatic test_order;
        logic [2:0] r; int lat, bc; logic da, e;
        prog_write(3'd0, 8'hA4);
        prog_write(3'd1, 8'hC9);
        run(4'd2, 1'b0, 3'b010, 1'b0, 8'h00, 1'b0, r, lat, bc, da, e);
        checks++; if (r !== 3'b111) begin failures++; $display("FAIL order_fwd got=%b exp=111", r); end
        checks++; if (lat != 3) begin failures++; $display("FAIL order_latency got=%0d exp=3", lat); end
        run(4'd2, 1'b1, 3'b111, 1'b0, 8'h00, 1'b0, r, lat, bc, da, e);
        checks++; if (r !== 3'b010) begin failures++; $display("FAIL order_inverse got=%b exp=010", r); end
        checks++; if (bc != 2) begin failures++; $display("FAIL order_inv_busy got=%0d exp=2", bc); end
        run(4'd2, 1'b0, 3'b111, 1'b0, 8'h00, 1'b0, r, lat, bc, da, e);
        checks++; if (r !== 3'b011) begin failures++; $display("FAIL order_fwd111 got=%b exp=011", r); end
    endtask

    task automatic test_len0;
        logic [2:0] r; int lat, bc; logic da, e;
        run(4'd0, 1'b0, 3'b101, 1'b0, 8'h00, 1'b0, r, lat, bc, da, e);
        checks++; if (r !== 3'b101) begin failures++; $display("FAIL len0_out got=%b exp=101", r); end
        checks++; if (lat != 1) begin failures++; $display("FAIL len0_latency got=%0d exp=1", lat); end
        checks++; if (bc != 0) begin failures++; $display("FAIL len0_busy got=%0d exp=0", bc); end
    endtask

    task automatic test_len_clamp;
        logic [2:0] r; int lat, bc; logic da, e;
        for (int i = 0; i < DEPTH; i++) prog_write(AW'(i), 8'h40);  // NOT C everywhere
        run(4'd11, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, r, lat, bc, da, e);
        checks++; if (bc != DEPTH) begin failures++; $display("FAIL clamp_busy got=%0d exp=%0d", bc, DEPTH); end
        checks++; if (r !== 3'b000) begin failures++; $display("FAIL clamp_out got=%b exp=000", r); end
        checks++; if (lat != DEPTH + 1) begin failures++; $display("FAIL clamp_latency got=%0d exp=%0d", lat, DEPTH + 1); end
        run(4'd8, 1'b1, 3'b001, 1'b0, 8'h00, 1'b0, r, lat, bc, da, e);
        checks++; if (r !== 3'b001) begin failures++; $display("FAIL clamp_inv_out got=%b exp=001", r); end
    endtask

    task automatic test_illegal;
        logic [2:0] r; int lat, bc; logic da, e;
        prog_write(3'd0, 8'h60);  // NOT A
        prog_write(3'd1, 8'hA8);  // CNOT tgt A, c1 A
        run(4'd2, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, r, lat, bc, da, e);
        checks++; if (r !== 3'b100) begin failures++; $display("FAIL illegal_out got=%b exp=100", r); end
        checks++; if (lat >= 100) begin failures++; $display("FAIL illegal_done_timeout got=%0d exp<100", lat); end
`ifdef GATE_CHECK_EN
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL illegal_err got=%b exp=1", e); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL illegal_err_sticky got=%b exp=1", err); end
`else
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL illegal_err got=%b exp=0", e); end
`endif
        prog_write(3'd1, 8'h00);
        run(4'd2, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, r, lat, bc, da, e);
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL illegal_err_clear got=%b exp=0", e); end
    endtask

    task automatic test_busy_protect;
        logic [2:0] r; int lat, bc; logic da, e;
        prog_write(3'd0, 8'hA4);
        prog_write(3'd1, 8'hC9);
        run(4'd2, 1'b0, 3'b010, 1'b0, 8'h00, 1'b1, r, lat, bc, da, e);
        checks++; if (r !== 3'b111) begin failures++; $display("FAIL protect_out got=%b exp=111", r); end
        checks++; if (lat != 3) begin failures++; $display("FAIL protect_latency got=%0d exp=3", lat); end
        run(4'd2, 1'b0, 3'b010, 1'b0, 8'h00, 1'b0, r, lat, bc, da, e);
        checks++; if (r !== 3'b111) begin failures++; $display("FAIL protect_rerun got=%b exp=111", r); end
    endtask

    task automatic test_we_start;
        logic [2:0] r; int lat, bc; logic da, e;
        prog_write(3'd0, 8'h00);
        run(4'd1, 1'b0, 3'b000, 1'b1, 8'h60, 1'b0, r, lat, bc, da, e);
        checks++; if (r !== 3'b100) begin failures++; $display("FAIL we_start_out got=%b exp=100", r); end
    endtask

    task automatic test_reset_mid;
        logic [2:0] r; int lat, bc; logic da, e; int seen;
        for (int i = 0; i < 4; i++) prog_write(AW'(i), 8'h40);
        @(posedge clk); #1;
        start = 1'b1; prog_len = 4'd4; dir = 1'b0; {A, B, C} = 3'b000;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (Out !== 3'b000) begin failures++; $display("FAIL midrst_out got=%b exp=000", Out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL midrst_done got=%0d exp=0", seen); end
        run(4'd1, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, r, lat, bc, da, e);
        checks++; if (r !== 3'b000) begin failures++; $display("FAIL midrst_prog_cleared got=%b exp=000", r); end
    endtask

    initial begin
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
        start = 1'b0; dir = 1'b0; A = 1'b0; B = 1'b0; C = 1'b0;
        test_reset();
        test_toffoli();
        test_order();
        test_len0();
        test_len_clamp();
        test_illegal();
        test_busy_protect();
        test_we_start();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
